icache_dm: RTL and testbench
============================

Name: icache_dm

Overview:
- Direct-mapped instruction cache: the fetch-side responder to the program counter.
- Accepts the PC fetch address and returns the 32-bit instruction.
- Hit: same-cycle, combinational. Miss: a refill FSM fetches a 4-word line from instruction memory and asserts stall, so the PC holds (write enable low).
- Sits between the PC register and the instruction memory port.

Parameters:
- LENGTH, 32, address and instruction width.
- NLINES, 4, number of cache lines; power of two, at least 2.
- CNT_W, 16, width of the saturating miss counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  fetch request valid.
- addr  input  LENGTH  fetch address from the PC.
- instr  output  LENGTH  instruction word; 0 when hit=0.
- hit  output  1  instr valid this cycle.
- stall  output  1  requester must hold addr and not advance.
- inval  input  1  invalidate all lines.
- mem_rd  output  1  line read request to memory.
- mem_addr  output  LENGTH  line-aligned read address.
- mem_ready  input  1  mem_data valid; completes the read.
- mem_data  input  4*LENGTH  line data; word0 in bits [LENGTH-1:0].
- miss_cnt  output  CNT_W  saturating count of misses started.

Behaviour:
- Reset is asynchronous, active-high. While asserted or after reset:
  - all valid bits 0, state IDLE;
  - mem_rd=0, mem_addr=0, miss_cnt=0;
  - hit=0, instr=0, stall=req, i.e. the first request always misses.
- Address split: addr[1:0] ignored; addr[3:2] selects the word; index = addr[3+log2(NLINES):4]; tag = all remaining upper bits.
- Lookup (combinational, state IDLE only): hit = req & valid[index] & (tag_mem[index]==tag); instr = selected word when hit, else 0.
- stall = req & ~hit in IDLE; stall = 1 in REFILL regardless of req.
- FSM states: IDLE, REFILL.
  - IDLE: if req & ~hit, latch mem_addr = {addr[LENGTH-1:4],4'b0}, increment miss_cnt (saturate at all-ones), and go to REFILL. mem_rd rises on the next cycle.
  - IDLE with req=0: no activity, stall=0.
  - REFILL: mem_rd=1 and mem_addr held stable until the cycle with mem_ready=1. In that cycle, write mem_data into the line at the latched index, write the tag, set valid, and go to IDLE. mem_rd is 0 the following cycle.
  - mem_ready while in IDLE is ignored.
- Latency:
  - hit: 0 cycles.
  - miss with mem_ready first sampled high k cycles after mem_rd rises: hit occurs k+2 cycles after the miss cycle. Example, k=0: miss at T, mem_rd at T+1 with mem_ready, hit at T+2.
- addr changing during REFILL: the refill still completes to the latched line. Lookup in IDLE then uses the new addr.
- inval (synchronous):
  - clears every valid bit in the cycle it is sampled;
  - has priority over a same-cycle refill write, so that line is written but left invalid;
  - does not abort REFILL (memory protocol requires mem_rd held until mem_ready);
  - inval in IDLE with a hit: that cycle still reports the hit (pre-clear state).
- Reset mid-REFILL: immediate return to IDLE with mem_rd=0. The outstanding memory read is abandoned and the memory side must tolerate this.
- Conflict miss: same index, different tag → refill overwrites the line.

Test Plan:
- Cold miss:
  - Stimulus: reset, then req=1, addr=0x100. mem_ready=1 two cycles after mem_rd rises, mem_data words 0xA0..0xA3.
  - Required: stall=1 from the first cycle; mem_rd=1 with mem_addr=0x100 for 3 cycles; then hit=1, instr=0xA0; miss_cnt=1.
- Same-line hits:
  - Stimulus: after the above, addr=0x104, 0x108, 0x10C on consecutive cycles.
  - Required: hit=1 each cycle with instr=0xA1, 0xA2, 0xA3; stall=0; mem_rd=0.
- Conflict eviction (NLINES=4):
  - Stimulus: miss at 0x140 (same index as 0x100), refill with 0xB0..0xB3, then addr=0x100.
  - Required: 0x140 hits with 0xB0 after refill; 0x100 misses again; miss_cnt=3.
- Invalidate:
  - Stimulus: inval=1 for one cycle, then addr=0x140.
  - Required: miss, mem_addr=0x140.
  - Stimulus: inval asserted in the same cycle as mem_ready.
  - Required: the next lookup of that line still misses.
- Address change mid-refill:
  - Stimulus: miss at 0x200, change addr to 0x300 before mem_ready.
  - Required: mem_addr stays 0x200; after refill, 0x300 misses and a new refill starts at 0x300.
- Reset mid-refill and counter saturation:
  - Stimulus: reset during REFILL.
  - Required: mem_rd=0 and miss_cnt=0 immediately, all lines invalid.
  - Stimulus: CNT_W=2 with 5 misses.
  - Required: miss_cnt=3.

Source files
------------

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with a 4-word line refill FSM.
// Hits are answered combinationally; misses stall the PC until the line is fetched.
module icache_dm #(
  parameter int unsigned LENGTH = 32,
  parameter int unsigned NLINES = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [LENGTH-1:0]     addr,
  output logic [LENGTH-1:0]     instr,
  output logic                  hit,
  output logic                  stall,
  input  logic                  inval,
  output logic                  mem_rd,
  output logic [LENGTH-1:0]     mem_addr,
  input  logic                  mem_ready,
  input  logic [4*LENGTH-1:0]   mem_data,
  output logic [CNT_W-1:0]      miss_cnt
);

  localparam int unsigned IDX_W = $clog2(NLINES);
  localparam int unsigned TAG_W = LENGTH - 4 - IDX_W;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t                 state;
  logic [NLINES-1:0]      valid;
  logic [TAG_W-1:0]       tag_mem  [NLINES];
  logic [LENGTH-1:0]      data_mem [NLINES][4];

  logic [1:0]             word;
  logic [IDX_W-1:0]       idx;
  logic [TAG_W-1:0]       tag;
  logic [IDX_W-1:0]       fill_idx;
  logic [TAG_W-1:0]       fill_tag;

  assign word     = addr[3:2];
  assign idx      = addr[4 +: IDX_W];
  assign tag      = addr[LENGTH-1 -: TAG_W];
  assign fill_idx = mem_addr[4 +: IDX_W];
  assign fill_tag = mem_addr[LENGTH-1 -: TAG_W];

  // Lookup is only meaningful in IDLE; a refill in flight always stalls.
  always_comb begin
    hit   = 1'b0;
    instr = '0;
    stall = 1'b0;
    if (state == REFILL) begin
      stall = 1'b1;
    end else begin
      hit   = req && valid[idx] && (tag_mem[idx] == tag);
      stall = req && !hit;
      if (hit) instr = data_mem[idx][word];
    end
  end

  // Control state, valid bits and miss counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      valid    <= '0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      miss_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            state    <= REFILL;
            mem_rd   <= 1'b1;
            mem_addr <= {addr[LENGTH-1:4], 4'b0000};
            if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
          end
        end
        REFILL: begin
          if (mem_ready) begin
            state           <= IDLE;
            mem_rd          <= 1'b0;
            valid[fill_idx] <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // Invalidate wins over a same-cycle fill: the line is written but stays invalid.
      if (inval) valid <= '0;
    end
  end

  // Tag and data arrays need no reset; they are qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_ready) begin
      tag_mem[fill_idx]        <= fill_tag;
      data_mem[fill_idx][2'd0] <= mem_data[LENGTH-1:0];
      data_mem[fill_idx][2'd1] <= mem_data[2*LENGTH-1:LENGTH];
      data_mem[fill_idx][2'd2] <= mem_data[3*LENGTH-1:2*LENGTH];
      data_mem[fill_idx][2'd3] <= mem_data[4*LENGTH-1:3*LENGTH];
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm with an expected-instruction scoreboard.
// A second instance with a 2-bit miss counter shares the stimulus to check saturation.
module tb_icache_dm;

  logic         clk = 1'b0;
  logic         reset;
  logic         req;
  logic [31:0]  addr;
  logic         inval;
  logic         mem_ready;
  logic [127:0] mem_data;

  logic [31:0]  instr, mem_addr;
  logic         hit, stall, mem_rd;
  logic [15:0]  miss_cnt;

  logic [31:0]  instr_s, mem_addr_s;
  logic         hit_s, stall_s, mem_rd_s;
  logic [1:0]   miss_cnt_s;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  icache_dm #(.LENGTH(32), .NLINES(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .instr(instr), .hit(hit),
    .stall(stall), .inval(inval), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_data(mem_data), .miss_cnt(miss_cnt)
  );

  icache_dm #(.LENGTH(32), .NLINES(4), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .instr(instr_s), .hit(hit_s),
    .stall(stall_s), .inval(inval), .mem_rd(mem_rd_s), .mem_addr(mem_addr_s),
    .mem_ready(mem_ready), .mem_data(mem_data), .miss_cnt(miss_cnt_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a fetch; on a miss, serve the refill with k wait cycles after mem_rd rises.
  task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input bit miss,
                       input int k, input logic [31:0] w0, input bit inv_at_ready);
    logic [31:0] got;
    addr = a;
    req  = 1'b1;
    exp_q.push_back(exp);
    #1;
    chk("stall", 32'(stall), 32'(miss));
    chk("hit", 32'(hit), 32'(!miss));
    if (miss) begin
      chk("instr_on_miss", instr, 32'h0);
      tick();
      chk("mem_rd_rise", 32'(mem_rd), 32'h1);
      chk("mem_addr", mem_addr, {a[31:4], 4'h0});
      repeat (k) begin
        tick();
        chk("mem_rd_hold", 32'(mem_rd), 32'h1);
        chk("mem_addr_hold", mem_addr, {a[31:4], 4'h0});
        chk("stall_refill", 32'(stall), 32'h1);
      end
      mem_ready = 1'b1;
      mem_data  = {w0 + 32'd3, w0 + 32'd2, w0 + 32'd1, w0};
      inval     = inv_at_ready;
      tick();
      mem_ready = 1'b0;
      mem_data  = '0;
      inval     = 1'b0;
      #1;
      chk("mem_rd_fall", 32'(mem_rd), 32'h0);
    end
    if (inv_at_ready) begin
      chk("hit_after_inval_fill", 32'(hit), 32'h0);
      req = 1'b0;
      void'(exp_q.pop_front());
    end else begin
      chk("hit_after", 32'(hit), 32'h1);
      chk("mem_rd_idle", 32'(mem_rd), 32'h0);
      got = exp_q.pop_front();
      chk("instr", instr, got);
    end
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; addr = '0; inval = 1'b0; mem_ready = 1'b0; mem_data = '0;
    #12;
    chk("rst_mem_rd", 32'(mem_rd), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_miss_cnt", 32'(miss_cnt), 32'h0);
    chk("rst_stall_idle", 32'(stall), 32'h0);
    reset = 1'b0;
    tick();

    // Cold miss with k=2, then same-line hits.
    fetch(32'h100, 32'hA0, 1'b1, 2, 32'hA0, 1'b0);
    chk("miss_cnt_1", 32'(miss_cnt), 32'd1);
    tick(); fetch(32'h104, 32'hA1, 1'b0, 0, 32'h0, 1'b0);
    tick(); fetch(32'h108, 32'hA2, 1'b0, 0, 32'h0, 1'b0);
    tick(); fetch(32'h10C, 32'hA3, 1'b0, 0, 32'h0, 1'b0);

    // Conflict eviction at index 0.
    tick(); fetch(32'h140, 32'hB0, 1'b1, 0, 32'hB0, 1'b0);
    tick(); fetch(32'h100, 32'hA0, 1'b1, 1, 32'hA0, 1'b0);
    chk("miss_cnt_3", 32'(miss_cnt), 32'd3);

    // Invalidate, then a refill that coincides with another invalidate.
    tick(); req = 1'b0; inval = 1'b1;
    tick(); inval = 1'b0;
    fetch(32'h140, 32'hC0, 1'b1, 0, 32'hC0, 1'b1);
    tick(); fetch(32'h140, 32'hB0, 1'b1, 0, 32'hB0, 1'b0);
    chk("miss_cnt_5", 32'(miss_cnt), 32'd5);
    chk("sat_miss_cnt", 32'(miss_cnt_s), 32'd3);

    // Address change during refill.
    tick(); addr = 32'h200; req = 1'b1;
    #1; chk("stall_200", 32'(stall), 32'h1);
    tick(); chk("mem_addr_200", mem_addr, 32'h200);
    addr = 32'h300;
    tick(); chk("mem_addr_stable", mem_addr, 32'h200);
    chk("mem_rd_stable", 32'(mem_rd), 32'h1);
    mem_ready = 1'b1; mem_data = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    tick(); mem_ready = 1'b0; mem_data = '0;
    #1; chk("miss_300", 32'(hit), 32'h0);
    chk("stall_300", 32'(stall), 32'h1);
    tick(); chk("mem_addr_300", mem_addr, 32'h300);
    chk("mem_rd_300", 32'(mem_rd), 32'h1);
    chk("miss_cnt_7", 32'(miss_cnt), 32'd7);

    // Asynchronous reset in the middle of the refill.
    #2; reset = 1'b1;
    #1; chk("rst_mid_mem_rd", 32'(mem_rd), 32'h0);
    chk("rst_mid_miss_cnt", 32'(miss_cnt), 32'h0);
    chk("rst_mid_stall", 32'(stall), 32'h1);
    chk("rst_mid_hit", 32'(hit), 32'h0);
    #3; reset = 1'b0;
    addr = 32'h100;
    #1; chk("post_rst_miss", 32'(hit), 32'h0);
    chk("post_rst_instr", instr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
